// File: rtl/prefix_addsub_seq.sv
// prefix_addsub_seq
// Word-serial WIDTH-bit add/subtract sequencer. Each operand pair is pushed
// through one external shared 16-bit adder, one slice per cycle, LSB slice
// first. The carry is chained between slices. The full result, the carry-out
// and the signed overflow are returned over a valid/ready handshake.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; req_ready is high only in IDLE
//   req_a, req_b          operands (captured on accept)
//   req_sel               0 = A+B+cin, 1 = A+~B+cin
//   req_cin               carry into slice 0
//   rsp_valid/rsp_ready   response handshake
//   rsp_sum, rsp_cout     result modulo 2^WIDTH, carry out of MSB
//   rsp_ovf               two's-complement overflow
//   add_a, add_b          shared adder operands (add_b is not inverted here)
//   add_cin, add_sel      shared adder carry-in and add/sub select
//   add_o                 shared adder result, combinational from add_*
module prefix_addsub_seq #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_sel,
   input  logic             req_cin,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             rsp_ovf,
   output logic [15:0]      add_a,
   output logic [15:0]      add_b,
   output logic             add_cin,
   output logic             add_sel,
   input  logic [15:0]      add_o
);

   localparam int SLICES = WIDTH / 16;
   localparam int KW     = (SLICES > 1) ? $clog2(SLICES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, b_reg, work_reg, sum_reg, work_merge;
   logic             sel_reg, carry_reg, cout_reg, ovf_reg;
   logic [KW-1:0]    k_reg;
   logic [15:0]      a_slice, b_slice, b_eff;
   logic             last_slice, slice_carry, slice_ovf;

   // Current slice of each captured operand; the shift amount is k*16.
   assign a_slice    = 16'(a_reg >> {k_reg, 4'b0000});
   assign b_slice    = 16'(b_reg >> {k_reg, 4'b0000});
   assign last_slice = (k_reg == KW'(SLICES - 1));

   // Carry and overflow of the MSB of the current slice, reconstructed from
   // the adder inputs and its sum bit (the adder exposes no carry-out).
   assign b_eff       = add_sel ? ~add_b : add_b;
   assign slice_carry = (add_a[15] & b_eff[15]) | ((add_a[15] ^ b_eff[15]) & ~add_o[15]);
   assign slice_ovf   = (add_a[15] == b_eff[15]) & (add_o[15] != add_a[15]);

   // Working copy with the current slice replaced by the adder result.
   // It goes to a separate register so rsp_sum only changes when a whole
   // new result is complete.
   genvar gi;
   generate
      for (gi = 0; gi < SLICES; gi++) begin : g_merge
         assign work_merge[16*gi +: 16] = (k_reg == KW'(gi)) ? add_o : work_reg[16*gi +: 16];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      add_a      = 16'h0000;
      add_b      = 16'h0000;
      add_cin    = 1'b0;
      add_sel    = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_next = RUN;
            end
         end
         RUN: begin
            add_a   = a_slice;
            add_b   = b_slice;
            add_cin = carry_reg;
            add_sel = sel_reg;
            if (last_slice) begin
               state_next = DONE;
            end
         end
         DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         sel_reg   <= 1'b0;
         carry_reg <= 1'b0;
         k_reg     <= '0;
         work_reg  <= '0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  a_reg     <= req_a;
                  b_reg     <= req_b;
                  sel_reg   <= req_sel;
                  carry_reg <= req_cin;
                  k_reg     <= '0;
               end
            end
            RUN: begin
               work_reg  <= work_merge;
               carry_reg <= slice_carry;
               k_reg     <= k_reg + KW'(1);
               if (last_slice) begin
                  sum_reg  <= work_merge;
                  cout_reg <= slice_carry;
                  ovf_reg  <= slice_ovf;
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_sum  = sum_reg;
   assign rsp_cout = cout_reg;
   assign rsp_ovf  = ovf_reg;

endmodule
